// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 active-low hex keypad one column at a time, debounces both the
//   press and the release of a key, and presents the last accepted key as a
//   held 4-bit code with a one-cycle valid strobe. key_code feeds the
//   seven-segment decoder directly, so the last key stays on the display.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   row_n      keypad rows, active-low, pulled up, asynchronous to clk
//   col_n      column drive, active-low, exactly one bit low at all times
//   key_code   code of the last accepted key, held until the next one
//   key_valid  one-cycle strobe marking a newly accepted key_code
//   key_held   high from acceptance until the release has been debounced
module keypad_scanner #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_SCAN     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_PRESSED  = 2'd2,
    S_RELEASE  = 2'd3
  } state_t;

  // Index of the lowest 0 bit; also used on col_n, which has exactly one 0.
  function automatic logic [1:0] f_lowest_zero(input logic [3:0] v);
    if (!v[0])      return 2'd0;
    else if (!v[1]) return 2'd1;
    else if (!v[2]) return 2'd2;
    else            return 2'd3;
  endfunction

  // Physical key legend at row r, column c.
  function automatic logic [3:0] f_key_map(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'd0:    return 4'h1;
      4'd1:    return 4'h2;
      4'd2:    return 4'h3;
      4'd3:    return 4'hA;
      4'd4:    return 4'h4;
      4'd5:    return 4'h5;
      4'd6:    return 4'h6;
      4'd7:    return 4'hB;
      4'd8:    return 4'h7;
      4'd9:    return 4'h8;
      4'd10:   return 4'h9;
      4'd11:   return 4'hC;
      4'd12:   return 4'hE;
      4'd13:   return 4'h0;
      4'd14:   return 4'hF;
      default: return 4'hD;
    endcase
  endfunction

  logic [3:0]       r_rows_p0;
  logic [3:0]       r_rows_s;
  state_t           r_state;
  logic [DIV_W-1:0] r_div_cnt;
  logic [DEB_W-1:0] r_deb_cnt;
  logic [3:0]       r_pattern;
  logic [3:0]       r_col_n;
  logic [3:0]       r_key_code;
  logic             r_key_valid;
  logic             r_key_held;

  state_t           w_state_nxt;
  logic [DIV_W-1:0] w_div_nxt;
  logic [DEB_W-1:0] w_deb_nxt;
  logic [3:0]       w_pattern_nxt;
  logic [3:0]       w_col_nxt;
  logic [3:0]       w_code_nxt;
  logic             w_valid_nxt;
  logic             w_held_nxt;

  // Next-state logic. The key outputs are loaded on the edge that enters
  // S_PRESSED so that key_code already carries the new value during the
  // single cycle key_valid is high.
  always_comb begin
    w_state_nxt   = r_state;
    w_div_nxt     = r_div_cnt;
    w_deb_nxt     = r_deb_cnt;
    w_pattern_nxt = r_pattern;
    w_col_nxt     = r_col_n;
    w_code_nxt    = r_key_code;
    w_valid_nxt   = 1'b0;
    w_held_nxt    = r_key_held;

    case (r_state)
      S_SCAN: begin
        if (r_div_cnt == DIV_LAST) begin
          w_div_nxt = '0;
          if (r_rows_s == 4'b1111) begin
            w_col_nxt = {r_col_n[2:0], r_col_n[3]};
          end else begin
            w_pattern_nxt = r_rows_s;
            w_deb_nxt     = '0;
            w_state_nxt   = S_DEBOUNCE;
          end
        end else begin
          w_div_nxt = r_div_cnt + DIV_W'(1);
        end
      end

      S_DEBOUNCE: begin
        if (r_rows_s == r_pattern) begin
          if (r_deb_cnt == DEB_LAST) begin
            w_deb_nxt   = '0;
            w_code_nxt  = f_key_map(f_lowest_zero(r_pattern), f_lowest_zero(r_col_n));
            w_valid_nxt = 1'b1;
            w_held_nxt  = 1'b1;
            w_state_nxt = S_PRESSED;
          end else begin
            w_deb_nxt = r_deb_cnt + DEB_W'(1);
          end
        end else begin
          // Bounce or early release: retry the same column from scratch.
          w_div_nxt   = '0;
          w_state_nxt = S_SCAN;
        end
      end

      S_PRESSED: begin
        w_deb_nxt   = '0;
        w_state_nxt = S_RELEASE;
      end

      default: begin
        // Column stays driven so only the accepted key's column is watched.
        if (r_rows_s == 4'b1111) begin
          if (r_deb_cnt == DEB_LAST) begin
            w_held_nxt  = 1'b0;
            w_div_nxt   = '0;
            w_deb_nxt   = '0;
            w_state_nxt = S_SCAN;
          end else begin
            w_deb_nxt = r_deb_cnt + DEB_W'(1);
          end
        end else begin
          w_deb_nxt = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rows_p0   <= 4'b1111;
      r_rows_s    <= 4'b1111;
      r_state     <= S_SCAN;
      r_div_cnt   <= '0;
      r_deb_cnt   <= '0;
      r_pattern   <= '0;
      r_col_n     <= 4'b1110;
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      // Two-flop synchronizer for the asynchronous row inputs.
      r_rows_p0   <= row_n;
      r_rows_s    <= r_rows_p0;
      r_state     <= w_state_nxt;
      r_div_cnt   <= w_div_nxt;
      r_deb_cnt   <= w_deb_nxt;
      r_pattern   <= w_pattern_nxt;
      r_col_n     <= w_col_nxt;
      r_key_code  <= w_code_nxt;
      r_key_valid <= w_valid_nxt;
      r_key_held  <= w_held_nxt;
    end
  end

  assign col_n     = r_col_n;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
//   Drives keypad_scanner (SCAN_DIV=8, DEBOUNCE_CYCLES=4) from a model of the
//   physical keypad (a set of pressed keys shorting a row to the driven
//   column) and compares every cycle against a behavioural model of the
//   scanning/debouncing rules, plus literal expectations for key timing.
module tb_keypad_scanner;

  localparam int SD = 8;
  localparam int DB = 4;

  // Key legend indexed [row][column].
  localparam logic [3:0] KEYS [0:3][0:3] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  // Pressed keys, bit index = row*4 + column.
  logic [15:0] keys = 16'h0000;

  int checks = 0;
  int failures = 0;
  int n_pulses = 0;

  keypad_scanner #(
    .SCAN_DIV       (SD),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .row_n    (row_n),
    .col_n    (col_n),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  // A pressed key pulls its row low only while its column is driven low.
  always_comb begin
    row_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && (col_n[c] == 1'b0)) row_n[r] = 1'b0;
  end

  // ---------------- behavioural model ----------------
  // mode: 0 = looking for a key, 1 = confirming a press, 2 = waiting for release.
  // valid marks the one acceptance cycle; release counting starts after it.
  typedef struct packed {
    logic [1:0] mode;
    logic [1:0] col;
    int         timer;
    int         cnt;
    logic [3:0] pat;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [3:0] code;
    logic       valid;
    logic       held;
  } mdl_t;

  localparam mdl_t M_RST = '{mode: 2'd0, col: 2'd0, timer: 0, cnt: 0, pat: 4'h0,
                             s1: 4'hF, s2: 4'hF, code: 4'h0, valid: 1'b0, held: 1'b0};

  mdl_t m;

  function automatic int lowest0(input logic [3:0] v);
    for (int i = 0; i < 4; i++)
      if (v[i] == 1'b0) return i;
    return 0;
  endfunction

  function automatic mdl_t f_step(input mdl_t cur, input logic [3:0] pins);
    mdl_t nx;
    logic [3:0] seen;
    nx = cur;
    seen = cur.s2;
    if (cur.valid) begin
      nx.valid = 1'b0;
    end else begin
      case (cur.mode)
        2'd0: begin
          nx.timer = cur.timer + 1;
          if (nx.timer == SD) begin
            nx.timer = 0;
            if (seen == 4'hF) nx.col = cur.col + 2'd1;
            else begin
              nx.pat  = seen;
              nx.mode = 2'd1;
              nx.cnt  = 0;
            end
          end
        end
        2'd1: begin
          if (seen == cur.pat) begin
            nx.cnt = cur.cnt + 1;
            if (nx.cnt == DB) begin
              nx.code  = KEYS[lowest0(cur.pat)][cur.col];
              nx.valid = 1'b1;
              nx.held  = 1'b1;
              nx.mode  = 2'd2;
              nx.cnt   = 0;
            end
          end else begin
            nx.mode  = 2'd0;
            nx.timer = 0;
          end
        end
        default: begin
          if (seen == 4'hF) begin
            nx.cnt = cur.cnt + 1;
            if (nx.cnt == DB) begin
              nx.held  = 1'b0;
              nx.mode  = 2'd0;
              nx.timer = 0;
              nx.cnt   = 0;
            end
          end else begin
            nx.cnt = 0;
          end
        end
      endcase
    end
    nx.s2 = cur.s1;
    nx.s1 = pins;
    return nx;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= M_RST;
    else        m <= f_step(m, row_n);
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock and compare every output with the model.
  task automatic tick();
    logic [3:0] ec;
    @(negedge clk);
    ec = 4'b1111;
    ec[m.col] = 1'b0;
    if (key_valid === 1'b1) n_pulses++;
    check("cycle{col,code,valid,held}", {col_n, key_code, key_valid, key_held},
          {ec, m.code, m.valid, m.held});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_col(input logic [3:0] want, input int limit, input string name);
    int n;
    n = 0;
    while (col_n !== want && n < limit) begin
      tick();
      n++;
    end
    check(name, col_n, want);
  endtask

  task automatic wait_valid(input int limit, input string name);
    int n;
    n = 0;
    while (key_valid !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    check(name, key_valid, 1'b1);
  endtask

  task automatic wait_release(input int limit, input string name);
    int n;
    n = 0;
    while (key_held !== 1'b0 && n < limit) begin
      tick();
      n++;
    end
    check(name, key_held, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int p0;
    int n;

    ticks(2);
    check("rst_col", col_n, 4'b1110);
    check("rst_code", key_code, 4'h0);
    check("rst_valid", key_valid, 1'b0);
    check("rst_held", key_held, 1'b0);
    rst_n = 1'b1;

    // Idle scan: each column is driven for 8 cycles.
    ticks(7);
    check("idle_c0_hold", col_n, 4'b1110);
    tick();
    check("idle_c1", col_n, 4'b1101);
    ticks(8);
    check("idle_c2", col_n, 4'b1011);
    ticks(8);
    check("idle_c3", col_n, 4'b0111);
    ticks(8);
    check("idle_wrap", col_n, 4'b1110);

    // Clean press of row 2 / column 1 ('8').
    p0 = n_pulses;
    keys[2*4+1] = 1'b1;
    wait_col(4'b1101, 20, "press_reach_c1");
    ticks(11);
    check("press_not_yet", key_valid, 1'b0);
    tick();
    check("press_valid", key_valid, 1'b1);
    check("press_code", key_code, 4'h8);
    check("press_held", key_held, 1'b1);
    check("press_col", col_n, 4'b1101);
    tick();
    check("press_pulse_end", key_valid, 1'b0);
    ticks(20);
    check("press_col_hold", col_n, 4'b1101);
    check("press_one_pulse", n_pulses - p0, 1);
    keys = 16'h0000;
    ticks(5);
    check("release_held_still", key_held, 1'b1);
    tick();
    check("release_held_drop", key_held, 1'b0);
    ticks(7);
    check("resume_same_col", col_n, 4'b1101);
    tick();
    check("resume_next_col", col_n, 4'b1011);

    // Bouncing row 0 on column 3 ('A'), then a steady press.
    p0 = n_pulses;
    wait_col(4'b0111, 20, "bounce_reach_c3");
    for (int i = 0; i < 10; i++) begin
      keys[0*4+3] = (i % 2 == 0);
      ticks(2);
    end
    check("bounce_no_valid", n_pulses - p0, 0);
    keys[0*4+3] = 1'b1;
    wait_valid(100, "bounce_valid_seen");
    check("bounce_code", key_code, 4'hA);
    check("bounce_col", col_n, 4'b0111);
    keys = 16'h0000;
    wait_release(20, "bounce_release");
    check("bounce_one_pulse", n_pulses - p0, 1);

    // Rows 1 and 3 on column 0: lowest row wins ('4'); long hold.
    p0 = n_pulses;
    keys[1*4+0] = 1'b1;
    keys[3*4+0] = 1'b1;
    wait_valid(100, "multi_valid_seen");
    check("multi_code", key_code, 4'h4);
    check("multi_col", col_n, 4'b1110);
    ticks(200);
    check("hold_one_pulse", n_pulses - p0, 1);
    check("hold_held", key_held, 1'b1);
    check("hold_col", col_n, 4'b1110);

    // Release bounce: high 3, low 1, high 4.
    keys = 16'h0000;
    ticks(3);
    keys[1*4+0] = 1'b1;
    keys[3*4+0] = 1'b1;
    tick();
    keys = 16'h0000;
    ticks(5);
    check("relb_held_still", key_held, 1'b1);
    tick();
    check("relb_held_drop", key_held, 1'b0);
    check("relb_one_pulse", n_pulses - p0, 1);

    // Reset while confirming a press of row 0 / column 2 ('3').
    keys[0*4+2] = 1'b1;
    n = 0;
    while (m.mode != 2'd1 && n < 60) begin
      tick();
      n++;
    end
    check("rdeb_col", col_n, 4'b1011);
    check("rdeb_code_before", key_code, 4'h4);
    #2 rst_n = 1'b0;
    #1;
    check("rdeb_async_col", col_n, 4'b1110);
    check("rdeb_async_code", key_code, 4'h0);
    check("rdeb_async_held", key_held, 1'b0);
    check("rdeb_async_valid", key_valid, 1'b0);
    keys = 16'h0000;
    ticks(2);
    rst_n = 1'b1;
    p0 = n_pulses;
    ticks(40);
    check("rdeb_no_pulse", n_pulses - p0, 0);

    // Reset while waiting for release of the same key.
    keys[0*4+2] = 1'b1;
    wait_valid(100, "rrel_valid_seen");
    check("rrel_code", key_code, 4'h3);
    ticks(3);
    check("rrel_held", key_held, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rrel_async_col", col_n, 4'b1110);
    check("rrel_async_code", key_code, 4'h0);
    check("rrel_async_held", key_held, 1'b0);
    keys = 16'h0000;
    ticks(2);
    rst_n = 1'b1;
    p0 = n_pulses;
    ticks(40);
    check("rrel_no_pulse", n_pulses - p0, 0);
    check("rrel_code_after", key_code, 4'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
